// File: rtl/comparator_bist_driver_pkg.sv
// Shared types and helpers for the comparator self-test driver.
// Holds the state encoding, golden compare and result-width helper.
package comparator_bist_driver_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int err_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic logic [2:0] golden_cmp(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return {a == b, a > b, a < b};
  endfunction

endpackage

// File: rtl/comparator_bist_ref.sv
// Golden comparator: expected {e,g,l} for one operand pair.
// Purely combinational, unsigned compare.
module comparator_bist_ref
  import comparator_bist_driver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       egl
);

  assign egl = golden_cmp(32'(a), 32'(b));

endmodule

// File: rtl/comparator_bist_driver.sv
// Sweeps every (A,B) pair into a comparator and checks its e/g/l.
// Reports pass, error count and the first failing pair.
module comparator_bist_driver
  import comparator_bist_driver_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic                 e_in,
  input  logic                 g_in,
  input  logic                 l_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b
);

  localparam int EW = err_w(WIDTH);
  localparam int IW = 2 * WIDTH;
  localparam int SW = $clog2(SETTLE + 1);

  state_t         state;
  logic [IW-1:0]  idx;
  logic [SW-1:0]  cnt;
  logic           first;
  logic [2:0]     exp_egl;
  logic           miss;
  logic           last_cyc;
  logic [EW-1:0]  err_nxt;

  // A is the high half of the index so B wraps into A.
  assign a_out = idx[IW-1:WIDTH];
  assign b_out = idx[WIDTH-1:0];

  comparator_bist_ref #(.WIDTH(WIDTH)) u_ref (
    .a   (a_out),
    .b   (b_out),
    .egl (exp_egl)
  );

  assign miss     = {e_in, g_in, l_in} != exp_egl;
  assign last_cyc = cnt == SW'(SETTLE);
  assign err_nxt  = err_count + EW'(miss);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      first     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      case (state)
        IDLE: begin
          idx       <= '0;
          cnt       <= '0;
          first     <= 1'b0;
          err_count <= '0;
          fail_a    <= '0;
          fail_b    <= '0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (last_cyc) begin
            cnt       <= '0;
            err_count <= err_nxt;
            if (miss && !first) begin
              first  <= 1'b1;
              fail_a <= a_out;
              fail_b <= b_out;
            end
            if (idx == '1) begin
              state <= DONE;
              idx   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= err_nxt == '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state     <= RUN;
            idx       <= '0;
            cnt       <= '0;
            first     <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_bist_driver.sv
// Self-checking bench for comparator_bist_driver, WIDTH=2.
// Bench-side comparator models feed two driver instances.
module tb_comparator_bist_driver;

  localparam int W = 2;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start3;
  logic [W-1:0] a1, b1, a3, b3, fa1, fb1, fa3, fb3;
  logic e1, g1, l1, e3, g3, l3;
  logic busy1, done1, pass1, busy3, done3, pass3;
  logic [2*W:0] err1, err3;
  logic [2:0] p1a, p1b, p3a, p3b;
  int mode;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int err;
    int fa;
    int fb;
    bit pass;
    bit exact;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) begin
    p1a <= {a1 == b1, a1 > b1, a1 < b1};
    p1b <= p1a;
    p3a <= {a3 == b3, a3 > b3, a3 < b3};
    p3b <= p3a;
  end

  always_comb begin
    {e1, g1, l1} = {a1 == b1, a1 > b1, a1 < b1};
    case (mode)
      1: g1 = 1'b0;
      2: l1 = 1'b1;
      3: {e1, g1, l1} = p1b;
      default: ;
    endcase
  end

  assign {e3, g3, l3} = p3b;

  comparator_bist_driver #(.WIDTH(W), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a_out(a1), .b_out(b1),
    .e_in(e1), .g_in(g1), .l_in(l1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_a(fa1), .fail_b(fb1)
  );

  comparator_bist_driver #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .a_out(a3), .b_out(b3),
    .e_in(e3), .g_in(g3), .l_in(l3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_a(fa3), .fail_b(fb3)
  );

  function automatic exp_t model(input int m);
    exp_t r;
    bit [2:0] good, got;
    r = '{err: 0, fa: 0, fb: 0, pass: 1'b1, exact: 1'b1};
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        good = {a == b, a > b, a < b};
        got = good;
        if (m == 1) got[1] = 1'b0;
        if (m == 2) got[0] = 1'b1;
        if (got != good) begin
          if (r.err == 0) begin
            r.fa = a;
            r.fb = b;
          end
          r.err++;
        end
      end
    end
    r.pass = r.err == 0;
    return r;
  endfunction

  task automatic pulse1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic count_busy1(inout int n);
    while (busy1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({busy1, done1, pass1, a1, b1} !== '0) begin
      mismatched++;
      $display("FAIL reset_flags got %b want 0",
               {busy1, done1, pass1, a1, b1});
    end
    compared++;
    if ({err1, fa1, fb1} !== '0) begin
      mismatched++;
      $display("FAIL reset_results got %h want 0", {err1, fa1, fb1});
    end
    rst = 1'b0;
  endtask

  task automatic test_pair_order();
    exp_t e;
    int k;
    int bad = 0;
    mode = 0;
    sb.push_back(model(0));
    pulse1();
    for (int c = 0; c < 2 * N; c++) begin
      k = c / 2;
      if (!busy1 || a1 !== W'(k >> W) || b1 !== W'(k)) bad++;
      @(negedge clk);
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL pair_order bad_cycles=%0d want 0", bad);
    end
    compared++;
    if (busy1 !== 1'b0 || done1 !== 1'b1 || a1 !== 0 || b1 !== 0) begin
      mismatched++;
      $display("FAIL end_state busy=%b done=%b a=%0d b=%0d want 0 1 0 0",
               busy1, done1, a1, b1);
    end
    e = sb.pop_front();
    compared++;
    if (pass1 !== e.pass || err1 !== (2*W+1)'(e.err) ||
        fa1 !== W'(e.fa) || fb1 !== W'(e.fb)) begin
      mismatched++;
      $display("FAIL good_result got p=%b e=%0d fa=%0d fb=%0d want %b %0d %0d %0d",
               pass1, err1, fa1, fb1, e.pass, e.err, e.fa, e.fb);
    end
  endtask

  task automatic test_faults();
    exp_t e;
    int n;
    for (int m = 1; m <= 2; m++) begin
      mode = m;
      sb.push_back(model(m));
      pulse1();
      n = 0;
      count_busy1(n);
      compared++;
      if (n != 2 * N) begin
        mismatched++;
        $display("FAIL fault%0d_busy got %0d want %0d", m, n, 2 * N);
      end
      e = sb.pop_front();
      compared++;
      if (done1 !== 1'b1 || pass1 !== e.pass ||
          err1 !== (2*W+1)'(e.err) ||
          fa1 !== W'(e.fa) || fb1 !== W'(e.fb)) begin
        mismatched++;
        $display("FAIL fault%0d got d=%b p=%b e=%0d fa=%0d fb=%0d want 1 %b %0d %0d %0d",
                 m, done1, pass1, err1, fa1, fb1, e.pass, e.err, e.fa, e.fb);
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int n;
    mode = 1;
    pulse1();
    repeat (10) @(negedge clk);
    compared++;
    if (a1 !== 2'd1 || b1 !== 2'd1 || err1 !== 1) begin
      mismatched++;
      $display("FAIL abort_vec5 got a=%0d b=%0d e=%0d want 1 1 1",
               a1, b1, err1);
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({busy1, done1, pass1, a1, b1, err1, fa1, fb1} !== '0) begin
      mismatched++;
      $display("FAIL abort_clear got %h want 0",
               {busy1, done1, pass1, a1, b1, err1, fa1, fb1});
    end
    rst = 1'b0;
    mode = 0;
    repeat (2) @(negedge clk);
    compared++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy1, done1);
    end
    sb.push_back(model(0));
    pulse1();
    n = 0;
    count_busy1(n);
    e = sb.pop_front();
    compared++;
    if (n != 2 * N || pass1 !== e.pass || err1 !== (2*W+1)'(e.err)) begin
      mismatched++;
      $display("FAIL abort_rerun got n=%0d p=%b e=%0d want %0d %b %0d",
               n, pass1, err1, 2 * N, e.pass, e.err);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int n;
    mode = 1;
    sb.push_back(model(1));
    pulse1();
    n = 0;
    repeat (7) begin
      n++;
      @(negedge clk);
    end
    start1 = 1'b1;
    n++;
    @(negedge clk);
    start1 = 1'b0;
    count_busy1(n);
    compared++;
    if (n != 2 * N) begin
      mismatched++;
      $display("FAIL ignore_busy got %0d want %0d", n, 2 * N);
    end
    e = sb.pop_front();
    compared++;
    if (err1 !== (2*W+1)'(e.err) || fa1 !== W'(e.fa) ||
        fb1 !== W'(e.fb)) begin
      mismatched++;
      $display("FAIL ignore_result got e=%0d fa=%0d fb=%0d want %0d %0d %0d",
               err1, fa1, fb1, e.err, e.fa, e.fb);
    end
  endtask

  task automatic test_restart();
    exp_t e;
    int n;
    mode = 0;
    sb.push_back(model(0));
    pulse1();
    compared++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || pass1 !== 1'b0 ||
        err1 !== 0 || fa1 !== 0 || fb1 !== 0 ||
        a1 !== 0 || b1 !== 0) begin
      mismatched++;
      $display("FAIL restart_clear got b=%b d=%b p=%b e=%0d fa=%0d fb=%0d a=%0d b=%0d want 1 0 0 0 0 0 0 0",
               busy1, done1, pass1, err1, fa1, fb1, a1, b1);
    end
    n = 0;
    count_busy1(n);
    e = sb.pop_front();
    compared++;
    if (n != 2 * N || pass1 !== e.pass || err1 !== (2*W+1)'(e.err)) begin
      mismatched++;
      $display("FAIL restart_run got n=%0d p=%b e=%0d want %0d %b %0d",
               n, pass1, err1, 2 * N, e.pass, e.err);
    end
  endtask

  task automatic test_pipeline();
    exp_t e;
    int n;
    mode = 3;
    sb.push_back('{err: 1, fa: 0, fb: 0, pass: 1'b0, exact: 1'b0});
    pulse1();
    n = 0;
    count_busy1(n);
    e = sb.pop_front();
    compared++;
    if (pass1 !== e.pass || err1 == 0 || done1 !== 1'b1) begin
      mismatched++;
      $display("FAIL pipe_settle1 got p=%b e=%0d d=%b want p=0 e>0 d=1",
               pass1, err1, done1);
    end
    sb.push_back(model(0));
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    n = 0;
    while (busy3 && n < 400) begin
      n++;
      @(negedge clk);
    end
    compared++;
    if (n != 4 * N) begin
      mismatched++;
      $display("FAIL pipe3_busy got %0d want %0d", n, 4 * N);
    end
    e = sb.pop_front();
    compared++;
    if (done3 !== 1'b1 || pass3 !== e.pass ||
        err3 !== (2*W+1)'(e.err) || fa3 !== 0 || fb3 !== 0) begin
      mismatched++;
      $display("FAIL pipe_settle3 got d=%b p=%b e=%0d fa=%0d fb=%0d want 1 1 0 0 0",
               done3, pass3, err3, fa3, fb3);
    end
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    mode = 0;
    test_reset();
    test_pair_order();
    test_faults();
    test_abort();
    test_ignore_start();
    test_restart();
    test_pipeline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/comparator_bist_driver.md
# comparator_bist_driver

Self-test driver for the 8-bit magnitude comparator. It is the stimulus-and-check end of the comparator interface. On a start pulse it walks every (A, B) operand pair and presents each pair on its outputs. It samples the comparator's e/g/l response after a programmable settle time, checks it against an internal golden result, and reports the pass/fail status, the error count and the first failing pair. It sits next to the comparator in hardware self-test builds.

## Interface
- WIDTH, 8: operand width; the sweep covers 2^(2·WIDTH) pairs.
- SETTLE, 1: cycles a vector is held before sampling; must be ≥1.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; level-sampled
- a_out  out  WIDTH  operand A to the comparator
- b_out  out  WIDTH  operand B to the comparator
- e_in  in  1  comparator equal output
- g_in  in  1  comparator greater (A>B) output
- l_in  in  1  comparator less (A<B) output
- busy  out  1  sweep in progress
- done  out  1  sweep finished; results valid
- pass  out  1  done with err_count==0
- err_count  out  2·WIDTH+1  mismatching vectors in the last sweep
- fail_a, fail_b  out  WIDTH each  operands of the first mismatch; 0 if none

## Operation
- States: IDLE, RUN, DONE.
- On rst, go to IDLE. All outputs read 0 on the cycle after the reset edge.
- IDLE:
  - start=1 moves to RUN.
  - The pair index and settle counter are cleared.
  - err_count, fail_a, fail_b and the first-fail flag are cleared.
- Pair order: A is the outer counter and B the inner counter, both counting from 0 upward. The sequence is (0,0), (0,1), … (0,2^W−1), (1,0), … (2^W−1, 2^W−1).
- RUN:
  - Each vector is held SETTLE+1 cycles.
  - On the last cycle of the period, {e_in,g_in,l_in} is compared to the expected value: {A==B, A>B, A<B}, unsigned.
  - Any bit difference, including a non-one-hot response, is a mismatch.
  - A mismatch increments err_count.
  - On the first mismatch only, the pair is latched into fail_a/fail_b.
- Last pair sampled: go to DONE. a_out/b_out return to 0.
- DONE:
  - done=1 and busy=0 hold.
  - pass = (err_count==0).
  - start=1 clears the results and restarts directly into RUN, with the same timing as from IDLE.
- start while in RUN is ignored.
- err_count width is 2W+1 and holds the maximum count of 2^(2W) with no wrap or saturation.
- Inner counter wrap carries into the outer counter. Outer wrap is never reached, because the last pair ends the sweep.
- rst mid-sweep aborts immediately. No partial results are retained.

## Timing
- start seen high at edge t: busy=1 and a_out/b_out=(0,0) from cycle t+1.
- Vector k is presented in cycles t+1+k·(SETTLE+1) through t+k·(SETTLE+1)+SETTLE+1. It is sampled at the closing edge of that window.
- Comparator path latency must be ≤ SETTLE cycles for a pass. A combinational comparator passes with SETTLE=1.
- busy is high for exactly 2^(2W)·(SETTLE+1) cycles.
- done, pass, err_count and fail_* update at the same edge busy falls.
- err_count and fail_* are registered. They may be observed while busy as running values.

## Structure
- Shared package contents:
  - state encoding localparams (IDLE/RUN/DONE);
  - the golden compare function returning the 3-bit {e,g,l};
  - the err_count width expression.
- One sub-module, comparator_bist_ref: combinational, takes WIDTH-bit a and b and produces the expected {e,g,l}.
- The top holds the FSM, pair/settle counters and result registers.

## Test plan
All scenarios use WIDTH=2, SETTLE=1 (16 vectors) unless stated otherwise.
- Correct combinational comparator, 1-cycle start → busy for 32 cycles; then done=1, pass=1, err_count=0, fail_a=fail_b=0.
- Comparator with g stuck-at-0 → err_count=6, pass=0, fail_a=1, fail_b=0.
- Comparator with l stuck-at-1 → err_count=10, fail_a=0, fail_b=0.
- rst asserted during vector 5 → all outputs 0 next cycle, state IDLE. A fresh start then completes with err_count=0.
- start pulsed mid-sweep → ignored, busy still 32 cycles. start asserted in DONE → results cleared and a new sweep runs from (0,0).
- Comparator behind 2 pipeline registers:
  - SETTLE=3 → pass=1.
  - SETTLE=1 → pass=0, err_count>0.
